key_debounce: RTL and testbench

- Upstream conditioning stage for a raw push-button.
- Synchronises the asynchronous pin and rejects contact bounce with a counter-qualified state machine.
- Produces a clean level plus single-cycle press and release strobes.
- key_out drives the key input of powerup_reset, so a bouncing button can never fire a burst of resets.

---
 rtl/key_debounce_if.sv | 26 ++
 rtl/key_debounce.sv | 182 ++++++++++++++++++
 tb/tb_key_debounce.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: bundles the raw button pin and the conditioned outputs of
// key_debounce. The debouncer uses the slave modport; whoever drives the pin
// and consumes the strobes uses the master modport.
interface key_debounce_if;
   logic key_in;       // raw, asynchronous button pin
   logic key_out;      // debounced level, 1 = pressed
   logic key_press;    // one-cycle strobe on key_out rising
   logic key_release;  // one-cycle strobe on key_out falling
   logic key_long;     // one-cycle long-press strobe

   modport master (
      output key_in,
      input  key_out,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_out,
      output key_press,
      output key_release,
      output key_long
   );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: push-button conditioning stage.
// The raw pin is normalised to 1 = pressed, passed through a two-flop
// synchroniser, and then qualified by a counter-driven FSM. A level change
// is accepted only after DEBOUNCE_CYCLES+1 consecutive agreeing samples.
// Outputs are a clean level plus single-cycle press/release strobes.
// The optional long-press detector is enabled by defining the macro
// KEY_DEBOUNCE_LONG_PRESS_EN; without it key_long is tied to 0.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int ACTIVE_LOW        = 0,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic          clk,
   input  logic          rst,
   key_debounce_if.slave kb
);

   localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          PIN_INV   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   localparam logic [1:0] ST_RELEASED      = 2'd0;
   localparam logic [1:0] ST_PRESS_CHECK   = 2'd1;
   localparam logic [1:0] ST_PRESSED       = 2'd2;
   localparam logic [1:0] ST_RELEASE_CHECK = 2'd3;

   logic          sync1_d, sync1_q;
   logic          sync2_d, sync2_q;
   logic          key_s;
   logic [1:0]    state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          key_out_d, key_out_q;
   logic          key_press_d, key_press_q;
   logic          key_release_d, key_release_q;
   logic          enter_pressed_s;

   // Synchroniser next-state: normalise polarity, then shift one stage.
   always_comb begin
      sync1_d = kb.key_in ^ PIN_INV;
      sync2_d = sync1_q;
   end

   // Synchroniser flops; both reset to the released value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign key_s = sync2_q;

   // Debounce FSM: a change is accepted only after the qualification counter
   // reaches its last value with the synchronised key still agreeing.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      key_out_d       = key_out_q;
      key_press_d     = 1'b0;
      key_release_d   = 1'b0;
      enter_pressed_s = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (key_s) begin
               state_d = ST_PRESS_CHECK;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_RELEASED;
            end
         end
         ST_PRESS_CHECK: begin
            if (!key_s) begin
               state_d = ST_RELEASED;
            end else if (cnt_q == CNT_LAST) begin
               state_d         = ST_PRESSED;
               key_out_d       = 1'b1;
               key_press_d     = 1'b1;
               enter_pressed_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!key_s) begin
               state_d = ST_RELEASE_CHECK;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_PRESSED;
            end
         end
         ST_RELEASE_CHECK: begin
            if (key_s) begin
               state_d = ST_PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = ST_RELEASED;
               key_out_d     = 1'b0;
               key_release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d   = ST_RELEASED;
            cnt_d     = CNT_ZERO;
            key_out_d = 1'b0;
         end
      endcase
   end

   // FSM state, qualification counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RELEASED;
         cnt_q         <= CNT_ZERO;
         key_out_q     <= 1'b0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         key_out_q     <= key_out_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
      end
   end

   assign kb.key_out     = key_out_q;
   assign kb.key_press   = key_press_q;
   assign kb.key_release = key_release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
   localparam logic [31:0] LP_ONE  = 32'd1;
   localparam logic [31:0] LP_LAST = 32'(LONG_PRESS_CYCLES - 1);
   localparam logic [31:0] LP_SAT  = 32'(LONG_PRESS_CYCLES);

   logic [31:0] lp_cnt_d, lp_cnt_q;
   logic        key_long_d, key_long_q;

   // Long-press timer: counts held cycles since key_out rose and saturates
   // one past the threshold so each press yields at most one strobe.
   always_comb begin
      lp_cnt_d   = lp_cnt_q;
      key_long_d = 1'b0;
      if (enter_pressed_s) begin
         lp_cnt_d = 32'd0;
      end else if ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHECK)) begin
         key_long_d = (lp_cnt_q == LP_LAST) ? 1'b1 : 1'b0;
         if (lp_cnt_q < LP_SAT) begin
            lp_cnt_d = lp_cnt_q + LP_ONE;
         end else begin
            lp_cnt_d = lp_cnt_q;
         end
      end else begin
         lp_cnt_d = lp_cnt_q;
      end
   end

   // Long-press counter and strobe flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lp_cnt_q   <= 32'd0;
         key_long_q <= 1'b0;
      end else begin
         lp_cnt_q   <= lp_cnt_d;
         key_long_q <= key_long_d;
      end
   end

   assign kb.key_long = key_long_q;
`else
   // The long-press threshold has no effect in this build.
   logic unused_lp_s;
   assign unused_lp_s = (LONG_PRESS_CYCLES > 0) ? 1'b1 : 1'b0;
   assign kb.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: drives an active-high and an active-low key_debounce with
// the same logical button activity and checks both against a run-length
// reference model: the level flips once DEBOUNCE_CYCLES+1 consecutive
// synchronised samples disagree with it.
module tb_key_debounce;
   localparam int D = 4;
   localparam int L = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_debounce_if bus_hi ();
   key_debounce_if bus_lo ();

   key_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0), .LONG_PRESS_CYCLES(L)) dut_hi (
      .clk(clk), .rst(rst), .kb(bus_hi)
   );
   key_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .LONG_PRESS_CYCLES(L)) dut_lo (
      .clk(clk), .rst(rst), .kb(bus_lo)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit pin;          // logical button state, 1 = pressed
   bit pq[$];        // samples in flight through the synchroniser
   bit lvl;          // expected debounced level
   int run;          // consecutive samples disagreeing with lvl
   int since_rise;   // edges since key_out rose
   bit e_press, e_rel, e_long;

   task automatic set_pin(input bit pressed);
      pin = pressed;
      bus_hi.key_in = pressed;
      bus_lo.key_in = ~pressed;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) begin
         lvl = 1'b0; run = 0; since_rise = 0;
         pq = {1'b0, 1'b0};
         e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      end else begin
         bit samp;
         samp = pq.pop_front();
         pq.push_back(pin);
         e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
         if (lvl) begin
            since_rise++;
            if (since_rise == L) e_long = 1'b1;
         end
         if (samp != lvl) run++;
         else run = 0;
         if (run == D + 1) begin
            lvl = ~lvl;
            run = 0;
            if (lvl) begin
               e_press = 1'b1;
               since_rise = 0;
            end else begin
               e_rel = 1'b1;
            end
         end
      end
`ifndef KEY_DEBOUNCE_LONG_PRESS_EN
      e_long = 1'b0;
`endif
      #1;
      chk("hi_key_out",     bus_hi.key_out,     lvl);
      chk("hi_key_press",   bus_hi.key_press,   e_press);
      chk("hi_key_release", bus_hi.key_release, e_rel);
      chk("hi_key_long",    bus_hi.key_long,    e_long);
      chk("hi_strobe_excl", bus_hi.key_press & bus_hi.key_release, 1'b0);
      chk("lo_key_out",     bus_lo.key_out,     lvl);
      chk("lo_key_press",   bus_lo.key_press,   e_press);
      chk("lo_key_release", bus_lo.key_release, e_rel);
      chk("lo_key_long",    bus_lo.key_long,    e_long);
   endtask

   task automatic hold(input bit pressed, input int cycles);
      set_pin(pressed);
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      rst = 1'b1;
      set_pin(1'b0);
      pq = {1'b0, 1'b0};

      // Reset held while the pin toggles every cycle
      for (int i = 0; i < 10; i++) begin
         set_pin(i[0]);
         step();
      end
      set_pin(1'b0);
      rst = 1'b0;
      hold(1'b0, 10);

      // Clean press and release
      hold(1'b1, 30);
      hold(1'b0, 30);

      // Bounce while released: 3 high / 2 low
      for (int i = 0; i < 50; i++) begin
         set_pin((i % 5) < 3);
         step();
      end
      hold(1'b0, 20);

      // Bounce while pressed
      hold(1'b1, 20);
      for (int i = 0; i < 50; i++) begin
         set_pin((i % 5) < 3);
         step();
      end
      hold(1'b1, 10);
      hold(1'b0, 20);

      // Key held through reset is a fresh press
      set_pin(1'b1);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b0;
      hold(1'b1, 30);
      hold(1'b0, 30);

      // Long press, then a press shorter than the threshold
      hold(1'b1, 60);
      hold(1'b0, 30);
      hold(1'b1, 15);
      hold(1'b0, 30);

      // Reset mid-qualification and mid-press
      set_pin(1'b1);
      step(); step(); step();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      hold(1'b0, 20);
      hold(1'b1, 15);
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      hold(1'b0, 20);

      // Randomised runs of varying length
      for (int r = 0; r < 60; r++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
      hold(1'b1, 40);
      hold(1'b0, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
